// File: rtl/cam_pattern_gen.sv
// Synthetic OV7670-style RGB565 camera source: vsync/href/byte stream with selectable test patterns.
// States: IDLE (outputs low, wait for en) | VSYNC (vsync high) | VBP (back porch) | ACTIVE (lines with href) | VFP (front porch, frame_done on last cycle)
module cam_pattern_gen #(
   parameter int H_ACTIVE    = 160,
   parameter int V_ACTIVE    = 120,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BP        = 17,
   parameter int V_FP        = 10
) (
   input  logic        CAM_pclk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] solid_rgb,
   output logic        CAM_vsync,
   output logic        CAM_href,
   output logic [7:0]  CAM_px_data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
   localparam int HW       = $clog2(LINE_LEN);
   localparam int LW       = $clog2(VSYNC_LINES + V_BP + V_ACTIVE + V_FP + 1);
   localparam int BAR_W    = (H_ACTIVE/8 < 1) ? 1 : H_ACTIVE/8;
   localparam int BW       = $clog2(BAR_W + 1);

   localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(2*H_ACTIVE);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_VSYNC  = 3'd1;
   localparam logic [2:0] S_VBP    = 3'd2;
   localparam logic [2:0] S_ACTIVE = 3'd3;
   localparam logic [2:0] S_VFP    = 3'd4;

   logic [2:0]    state, state_nxt;
   logic [HW-1:0] h_pos, h_nxt;
   logic [LW-1:0] lines_left, lines_nxt;
   logic [1:0]    pat_q;
   logic [15:0]   solid_q;
   logic [15:0]   pix_cnt;
   logic [2:0]    bar_idx;
   logic [BW-1:0] bar_left;

   logic          href_nxt;
   logic          vsync_entry;
   logic          done_nxt;
   logic [5:0]    px_x;
   logic [15:0]   bar_rgb;
   logic [15:0]   pixel;
   logic [7:0]    data_nxt;

   // h_pos walks every line period; lines_left counts down the line periods left in the state
   always_comb begin
      state_nxt = state;
      h_nxt     = h_pos;
      lines_nxt = lines_left;
      if (state == S_IDLE) begin
         if (en) begin
            state_nxt = S_VSYNC;
            h_nxt     = '0;
            lines_nxt = LW'(VSYNC_LINES - 1);
         end
      end else if (h_pos != H_LAST) begin
         h_nxt = h_pos + HW'(1);
      end else begin
         h_nxt = '0;
         if (lines_left != '0) begin
            lines_nxt = lines_left - LW'(1);
         end else begin
            case (state)
               S_VSYNC: begin
                  if (V_BP == 0) begin
                     state_nxt = S_ACTIVE;
                     lines_nxt = LW'(V_ACTIVE - 1);
                  end else begin
                     state_nxt = S_VBP;
                     lines_nxt = LW'(V_BP - 1);
                  end
               end
               S_VBP: begin
                  state_nxt = S_ACTIVE;
                  lines_nxt = LW'(V_ACTIVE - 1);
               end
               S_ACTIVE: begin
                  state_nxt = S_VFP;
                  lines_nxt = LW'(V_FP - 1);
               end
               S_VFP: begin
                  if (en) begin
                     state_nxt = S_VSYNC;
                     lines_nxt = LW'(VSYNC_LINES - 1);
                  end else begin
                     state_nxt = S_IDLE;
                     lines_nxt = '0;
                  end
               end
               default: begin
                  state_nxt = S_IDLE;
                  lines_nxt = '0;
               end
            endcase
         end
      end
   end

   // Outputs are registered from the next-cycle position so they line up with the state they describe
   always_comb begin
      href_nxt    = (state_nxt == S_ACTIVE) && (h_nxt < H_ACT_END);
      vsync_entry = (state_nxt == S_VSYNC) && (state != S_VSYNC);
      done_nxt    = (state_nxt == S_VFP) && (h_nxt == H_LAST) && (lines_nxt == '0);
      px_x        = 6'(h_nxt >> 1);

      case (bar_idx)
         3'd0:    bar_rgb = 16'hFFFF;
         3'd1:    bar_rgb = 16'hFFE0;
         3'd2:    bar_rgb = 16'h07FF;
         3'd3:    bar_rgb = 16'h07E0;
         3'd4:    bar_rgb = 16'hF81F;
         3'd5:    bar_rgb = 16'hF800;
         3'd6:    bar_rgb = 16'h001F;
         default: bar_rgb = 16'h0000;
      endcase

      case (pat_q)
         2'd0:    pixel = solid_q;
         2'd1:    pixel = bar_rgb;
         2'd2:    pixel = {px_x[4:0], px_x[5:0], px_x[4:0]};
         default: pixel = pix_cnt;
      endcase

      data_nxt = 8'h00;
      if (href_nxt) data_nxt = h_nxt[0] ? pixel[7:0] : pixel[15:8];
   end

   always_ff @(posedge CAM_pclk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         h_pos       <= '0;
         lines_left  <= '0;
         pat_q       <= '0;
         solid_q     <= '0;
         pix_cnt     <= '0;
         bar_idx     <= '0;
         bar_left    <= '0;
         CAM_vsync   <= 1'b0;
         CAM_href    <= 1'b0;
         CAM_px_data <= 8'h00;
         frame_done  <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         h_pos       <= h_nxt;
         lines_left  <= lines_nxt;
         CAM_vsync   <= (state_nxt == S_VSYNC);
         CAM_href    <= href_nxt;
         CAM_px_data <= data_nxt;
         frame_done  <= done_nxt;
         if (done_nxt) frame_cnt <= frame_cnt + 16'd1;

         if (vsync_entry) begin
            pat_q   <= pattern_sel;
            solid_q <= solid_rgb;
            pix_cnt <= '0;
         end else if (href_nxt && h_nxt[0]) begin
            pix_cnt <= pix_cnt + 16'd1;
         end

         // Bar position advances after each pixel's low byte and rewinds during blanking
         if (!href_nxt) begin
            bar_idx  <= '0;
            bar_left <= BW'(BAR_W - 1);
         end else if (h_nxt[0]) begin
            if (bar_left == '0) begin
               bar_left <= BW'(BAR_W - 1);
               if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_left <= bar_left - BW'(1);
            end
         end
      end
   end

endmodule
